// File: rtl/issue_control_pkg.sv
// Shared types for the issue controller: scoreboard entry layout,
// functional-unit codes, FSM state encoding and the instruction bundle.
package issue_control_pkg;

    localparam int REG_W   = 5;
    localparam int UNIT_W  = 2;
    localparam int STALL_W = 16;

    localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

    // Scoreboard entry: [7] pending, [6:5] unit, [4:0] position
    localparam int SB_PEND    = 7;
    localparam int SB_UNIT_HI = 6;
    localparam int SB_UNIT_LO = 5;
    localparam int SB_POS_HI  = 4;
    localparam int SB_POS_LO  = 0;

    typedef enum logic [UNIT_W-1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_LSU = 2'd2,
        UNIT_BRU = 2'd3
    } unit_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_RS  = 3'd1,
        ST_RD_RT  = 3'd2,
        ST_RD_RD  = 3'd3,
        ST_DECIDE = 3'd4
    } state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              uses_rs;
        logic              uses_rt;
        logic              writes_rd;
        logic [UNIT_W-1:0] unit;
    } instr_t;

    // r0 is hardwired, so it can never carry a hazard.
    function automatic logic sb_hazard(
        input logic             pend,
        input logic             used,
        input logic [REG_W-1:0] r
    );
        return pend & used & (r != '0);
    endfunction

endpackage

// File: rtl/issue_control_if.sv
// Issue bus between the controller and the functional units.
// master: drives valid and the latched instruction fields; slave: drives ready.
interface issue_control_if;
    import issue_control_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [UNIT_W-1:0] issue_unit;
    logic [REG_W-1:0]  issue_rs;
    logic [REG_W-1:0]  issue_rt;
    logic [REG_W-1:0]  issue_rd;

    modport master (
        output issue_valid,
        output issue_unit,
        output issue_rs,
        output issue_rt,
        output issue_rd,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_unit,
        input  issue_rs,
        input  issue_rt,
        input  issue_rd,
        output issue_ready
    );

endinterface

// File: rtl/issue_control.sv
// Issue controller: accepts one decoded instruction, polls the scoreboard
// for rs/rt/rd, stalls on RAW/WAW hazards, then issues and marks rd pending.
// Ports: clock/reset; decode side in_*; scoreboard lookup sb_addr/sb_data;
// scoreboard write sb_writeaddr/sb_registerstage/sb_enablewrite;
// issue bus (iss, master); stall_count saturating hazard counter.
module issue_control
    import issue_control_pkg::*;
(
    input  logic               clock,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    input  logic               in_uses_rs,
    input  logic               in_uses_rt,
    input  logic               in_writes_rd,
    input  logic [UNIT_W-1:0]  in_unit,

    output logic [REG_W-1:0]   sb_addr,
    input  logic [7:0]         sb_data,
    output logic [REG_W-1:0]   sb_writeaddr,
    output logic [UNIT_W-1:0]  sb_registerstage,
    output logic               sb_enablewrite,

    issue_control_if.master    iss,

    output logic [STALL_W-1:0] stall_count
);

    state_e             state_q;
    state_e             state_d;
    instr_t             ins_q;
    instr_t             ins_d;
    logic               haz_rs_q;
    logic               haz_rt_q;
    logic               haz_rd_q;
    logic               any_haz;
    logic               stall_inc;
    logic [STALL_W-1:0] stall_q;
    logic               sb_pend;
    logic               sb_unused;

    assign sb_pend   = sb_data[SB_PEND];
    assign sb_unused = ^{sb_data[SB_UNIT_HI:SB_UNIT_LO],
                         sb_data[SB_POS_HI:SB_POS_LO]};

    assign ins_d = '{
        rs:        in_rs,
        rt:        in_rt,
        rd:        in_rd,
        uses_rs:   in_uses_rs,
        uses_rt:   in_uses_rt,
        writes_rd: in_writes_rd,
        unit:      in_unit
    };

    assign any_haz = haz_rs_q | haz_rt_q | haz_rd_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        sb_addr        = ins_q.rd;
        iss.issue_valid = 1'b0;
        sb_enablewrite = 1'b0;
        stall_inc      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RD_RS;
                end
            end
            ST_RD_RS: begin
                sb_addr = ins_q.rs;
                state_d = ST_RD_RT;
            end
            ST_RD_RT: begin
                sb_addr = ins_q.rt;
                state_d = ST_RD_RD;
            end
            ST_RD_RD: begin
                sb_addr = ins_q.rd;
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (any_haz) begin
                    stall_inc = 1'b1;
                    state_d   = ST_RD_RS;
                end else begin
                    // Only this block sets pending, so a clean poll
                    // stays valid while the unit holds us off.
                    iss.issue_valid = 1'b1;
                    if (iss.issue_ready) begin
                        sb_enablewrite = ins_q.writes_rd & (ins_q.rd != '0);
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ins_q    <= '0;
            haz_rs_q <= 1'b0;
            haz_rt_q <= 1'b0;
            haz_rd_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                ins_q <= ins_d;
            end
            if (state_q == ST_RD_RS) begin
                haz_rs_q <= sb_hazard(sb_pend, ins_q.uses_rs, ins_q.rs);
            end
            if (state_q == ST_RD_RT) begin
                haz_rt_q <= sb_hazard(sb_pend, ins_q.uses_rt, ins_q.rt);
            end
            if (state_q == ST_RD_RD) begin
                haz_rd_q <= sb_hazard(sb_pend, ins_q.writes_rd, ins_q.rd);
            end
            if (stall_inc && stall_q != STALL_MAX) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign sb_writeaddr     = ins_q.rd;
    assign sb_registerstage = ins_q.unit;
    assign iss.issue_unit   = ins_q.unit;
    assign iss.issue_rs     = ins_q.rs;
    assign iss.issue_rt     = ins_q.rt;
    assign iss.issue_rd     = ins_q.rd;
    assign stall_count      = stall_q;

endmodule
